// File: rtl/mu0_loader.sv
// mu0_loader: byte-stream program loader for MU0 memory, holds CPU in reset.
// Optional trailing checksum when MU0_LOADER_CHECKSUM_EN is defined.
module mu0_loader #(
    parameter logic [11:0] START_ADDR = 12'h000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [7:0]  Byte_in,
    input  logic        Byte_valid,
    output logic        Byte_ready,
    output logic        Mem_wr,
    output logic [11:0] Mem_address,
    output logic [15:0] Mem_data,
    output logic        Cpu_reset,
    output logic        Load_done,
    output logic        Load_error
);

    typedef enum logic [3:0] {
        LEN_HI,
        LEN_LO,
        DATA_HI,
        DATA_LO,
        WRITE,
`ifdef MU0_LOADER_CHECKSUM_EN
        CSUM_HI,
        CSUM_LO,
`endif
        RUN,
        ERROR
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [12:0] cnt_q, cnt_d;
    logic [7:0]  hi_q, hi_d;
    logic [11:0] addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic        rdy_q, rdy_d;
    logic        wr_q, wr_d;
    logic        crst_q, crst_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
`ifdef MU0_LOADER_CHECKSUM_EN
    logic [15:0] csum_q, csum_d;
`endif

    logic        take;
    logic [15:0] word_w;

    assign take   = Byte_valid && rdy_q;
    assign word_w = {hi_q, Byte_in};

    // Next-state and datapath update; outputs are decoded from the next state
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        addr_d  = addr_q;
        data_d  = data_q;
`ifdef MU0_LOADER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        unique case (state_q)
            LEN_HI: begin
                if (take) begin
                    hi_d    = Byte_in;
                    state_d = LEN_LO;
                end
            end
            LEN_LO: begin
                if (take) begin
                    len_d = word_w;
                    if (word_w != 16'd0 && word_w <= 16'd4096)
                        state_d = DATA_HI;
                    else
                        state_d = ERROR;
                end
            end
            DATA_HI: begin
                if (take) begin
                    hi_d    = Byte_in;
                    state_d = DATA_LO;
                end
            end
            DATA_LO: begin
                if (take) begin
                    data_d  = word_w;
                    addr_d  = START_ADDR + cnt_q[11:0];
`ifdef MU0_LOADER_CHECKSUM_EN
                    csum_d  = csum_q + word_w;
`endif
                    state_d = WRITE;
                end
            end
            WRITE: begin
                cnt_d = cnt_q + 13'd1;
                if ({3'b000, cnt_d} == len_q)
`ifdef MU0_LOADER_CHECKSUM_EN
                    state_d = CSUM_HI;
`else
                    state_d = RUN;
`endif
                else
                    state_d = DATA_HI;
            end
`ifdef MU0_LOADER_CHECKSUM_EN
            CSUM_HI: begin
                if (take) begin
                    hi_d    = Byte_in;
                    state_d = CSUM_LO;
                end
            end
            CSUM_LO: begin
                if (take) begin
                    if (word_w == csum_q)
                        state_d = RUN;
                    else
                        state_d = ERROR;
                end
            end
`endif
            RUN:     state_d = RUN;
            ERROR:   state_d = ERROR;
            default: state_d = ERROR;
        endcase

        rdy_d  = (state_d == LEN_HI) || (state_d == LEN_LO) ||
                 (state_d == DATA_HI) || (state_d == DATA_LO);
`ifdef MU0_LOADER_CHECKSUM_EN
        rdy_d  = rdy_d || (state_d == CSUM_HI) || (state_d == CSUM_LO);
`endif
        wr_d   = (state_d == WRITE);
        crst_d = (state_d != RUN);
        done_d = (state_d == RUN);
        err_d  = (state_d == ERROR);
    end

    // State, datapath and registered Moore outputs with synchronous reset
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= LEN_HI;
            len_q   <= 16'd0;
            cnt_q   <= 13'd0;
            hi_q    <= 8'd0;
            addr_q  <= START_ADDR;
            data_q  <= 16'd0;
            rdy_q   <= 1'b1;
            wr_q    <= 1'b0;
            crst_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef MU0_LOADER_CHECKSUM_EN
            csum_q  <= 16'd0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            rdy_q   <= rdy_d;
            wr_q    <= wr_d;
            crst_q  <= crst_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef MU0_LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    assign Byte_ready  = rdy_q;
    assign Mem_wr      = wr_q;
    assign Mem_address = addr_q;
    assign Mem_data    = data_q;
    assign Cpu_reset   = crst_q;
    assign Load_done   = done_q;
    assign Load_error  = err_q;

endmodule
